// File: rtl/io_bridge.sv
// io_bridge: single-request bridge from the CPU data port to four
// memory-mapped peripheral slots.
// Decodes a 1 KiB window at BASE into a one-hot slot select from addr[9:8].
// It holds the request until the selected slot acknowledges, then returns
// that slot's read data with a one-cycle ready pulse.
// Optional feature macro: IO_BRIDGE_TIMEOUT_EN adds an ACCESS watchdog.
// When the macro is set and no ack arrives before the count reaches TIMEOUT,
// the request ends with an error response.
module io_bridge #(
    parameter logic [31:0] BASE    = 32'h0000_7F00,
    parameter int          TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_err,
    output logic [3:0]   dev_sel,
    output logic         dev_we,
    output logic [7:0]   dev_addr,
    output logic [31:0]  dev_wdata,
    input  logic [3:0]   dev_ack,
    input  logic [127:0] dev_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_err_q, cpu_err_d;
    logic [3:0]  dev_sel_q, dev_sel_d;
    logic        dev_we_q, dev_we_d;
    logic [7:0]  dev_addr_q, dev_addr_d;
    logic [31:0] dev_wdata_q, dev_wdata_d;

    logic        in_window;
    logic        ack_hit;
    logic [31:0] slot_rdata;

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
`else
    // The watchdog is not built; keep its parameter referenced.
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    assign in_window = (cpu_addr[31:10] == BASE[31:10]);
    // Only the bit of the slot currently selected can complete the access.
    assign ack_hit   = |(dev_ack & dev_sel_q);

    // Route the selected slot's read data; dev_sel_q is one-hot or zero.
    always_comb begin
        slot_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (dev_sel_q[i]) slot_rdata = slot_rdata | dev_rdata[32*i +: 32];
        end
    end

    // Next-state and next-output logic for the IDLE/ACCESS/RESP handshake.
    always_comb begin
        // NOTE: every _d signal gets a default first, so no path leaves a latch.
        state_d     = state_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = cpu_err_q;
        dev_sel_d   = dev_sel_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    dev_we_d    = cpu_we;
                    dev_addr_d  = cpu_addr[7:0];
                    dev_wdata_d = cpu_wdata;
                    if (in_window) begin
                        state_d   = S_ACCESS;
                        dev_sel_d = 4'b0001 << cpu_addr[9:8];
`ifdef IO_BRIDGE_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        state_d     = S_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                // Ack is checked first so it wins a tie with the timeout.
                if (ack_hit) begin
                    state_d     = S_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = slot_rdata;
                    cpu_err_d   = 1'b0;
                    dev_sel_d   = '0;
                end
`ifdef IO_BRIDGE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_C) begin
                    state_d     = S_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = '0;
                    cpu_err_d   = 1'b1;
                    dev_sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                dev_sel_d = '0;
            end
        endcase
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is plain flops, so all of it is cleared on reset.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            dev_sel_q   <= dev_sel_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign dev_sel   = dev_sel_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_io_bridge.sv
// Directed testbench for io_bridge.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Slot decode uses addr[9:8]. So 0x7C08 is slot 0, 0x7D10 is slot 1,
// 0x7E24 is slot 2, and 0x7F00/0x7F30 are slot 3.
module tb_io_bridge;

    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         cpu_err;
    logic [3:0]   dev_sel;
    logic         dev_we;
    logic [7:0]   dev_addr;
    logic [31:0]  dev_wdata;
    logic [3:0]   dev_ack;
    logic [127:0] dev_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    io_bridge #(.BASE(32'h0000_7F00), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop the strobe.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cpu_err); end
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_sel: got %b want 0000", dev_sel); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_slot2();
        issue(1'b0, 32'h0000_7E24, 32'h0);
        n_checks++; if (dev_sel !== 4'b0100) begin n_fail++; $display("FAIL rd_sel: got %b want 0100", dev_sel); end
        n_checks++; if (dev_addr !== 8'h24) begin n_fail++; $display("FAIL rd_addr: got %h want 24", dev_addr); end
        n_checks++; if (dev_we !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b want 0", dev_we); end
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rd_early_ready: got %b want 0", cpu_ready); end
        dev_ack = 4'b0100;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", cpu_rdata); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", cpu_err); end
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL rd_sel_drop: got %b want 0000", dev_sel); end
        tick();
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_pulse: got %b want 0", cpu_ready); end
        n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data_hold: got %h want deadbeef", cpu_rdata); end
        tick();
    endtask

    task automatic test_write_slot1();
        issue(1'b1, 32'h0000_7D10, 32'h1234_5678);
        // Three ack-less cycles; the first carries a spurious ack from slot 3.
        for (int i = 0; i < 3; i++) begin
            dev_ack = (i == 0) ? 4'b1000 : 4'b0000;
            n_checks++; if (dev_sel !== 4'b0010) begin n_fail++; $display("FAIL wr_sel[%0d]: got %b want 0010", i, dev_sel); end
            n_checks++; if (dev_we !== 1'b1) begin n_fail++; $display("FAIL wr_we[%0d]: got %b want 1", i, dev_we); end
            n_checks++; if (dev_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_wdata[%0d]: got %h want 12345678", i, dev_wdata); end
            n_checks++; if (dev_addr !== 8'h10) begin n_fail++; $display("FAIL wr_addr[%0d]: got %h want 10", i, dev_addr); end
            tick();
            n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL wr_early_ready[%0d]: got %b want 0", i, cpu_ready); end
        end
        dev_ack = 4'b0010;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", cpu_err); end
        n_checks++; if (cpu_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL wr_rdata: got %h want 22222222", cpu_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        issue(1'b1, 32'h0000_7F0C, 32'hA5A5_A5A5);
        tick(); tick();
        n_checks++; if (dev_sel !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_sel_before: got %b want 1000", dev_sel); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({cpu_ready, cpu_err, dev_sel, dev_we} !== 7'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000000", {cpu_ready, cpu_err, dev_sel, dev_we}); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (dev_addr !== 8'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h want 0", dev_addr); end
        n_checks++; if (dev_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_wdata: got %h want 0", dev_wdata); end
        tick();
        rst_n = 1'b1;
        tick();
        // A fresh request must be accepted, so the FSM is back in IDLE.
        issue(1'b0, 32'h0000_7F00, 32'h0);
        n_checks++; if (dev_sel !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_new_sel: got %b want 1000", dev_sel); end
        dev_ack = 4'b1000;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_new_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL rst_mid_new_rdata: got %h want 33333333", cpu_rdata); end
        tick();
    endtask

    task automatic test_out_of_window();
        issue(1'b0, 32'h0000_1000, 32'h0);
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL oow_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL oow_err: got %b want 1", cpu_err); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL oow_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL oow_sel: got %b want 0000", dev_sel); end
        tick();
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL oow_ready_pulse: got %b want 0", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL oow_err_hold: got %b want 1", cpu_err); end
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL oow_sel_after: got %b want 0000", dev_sel); end
        tick();
    endtask

    task automatic test_timeout();
        logic saw_ready;
        saw_ready = 1'b0;
        issue(1'b0, 32'h0000_7F30, 32'h0);
`ifdef IO_BRIDGE_TIMEOUT_EN
        // The count runs 0..TIMEOUT. The edge that sees TIMEOUT ends the access.
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (cpu_ready === 1'b1) saw_ready = 1'b1;
        end
        n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL to_early_ready: got %b want 0", saw_ready); end
        n_checks++; if (dev_sel !== 4'b1000) begin n_fail++; $display("FAIL to_sel_held: got %b want 1000", dev_sel); end
        tick();
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", cpu_err); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL to_sel_drop: got %b want 0000", dev_sel); end
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cpu_ready === 1'b1) saw_ready = 1'b1;
        end
        n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL nto_ready: got %b want 0", saw_ready); end
        n_checks++; if (dev_sel !== 4'b1000) begin n_fail++; $display("FAIL nto_sel_held: got %b want 1000", dev_sel); end
        dev_ack = 4'b1000;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL nto_ready_ack: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL nto_err: got %b want 0", cpu_err); end
        n_checks++; if (cpu_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL nto_rdata: got %h want 33333333", cpu_rdata); end
        tick();
`endif
    endtask

    task automatic test_tie_back_to_back();
        issue(1'b0, 32'h0000_7C08, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) tick();
        // The ack lands on the terminal-count cycle.
        dev_ack = 4'b0001;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL tie_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL tie_err: got %b want 0", cpu_err); end
        n_checks++; if (cpu_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL tie_rdata: got %h want 11111111", cpu_rdata); end
        // Present the next request while in RESP. It is ignored there and
        // accepted on the following IDLE edge.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7D44; cpu_wdata = 32'hCAFE_0001;
        tick();
        n_checks++; if (dev_sel !== 4'b0000) begin n_fail++; $display("FAIL b2b_resp_ignored: got %b want 0000", dev_sel); end
        tick();
        cpu_req = 1'b0;
        n_checks++; if (dev_sel !== 4'b0010) begin n_fail++; $display("FAIL b2b_sel: got %b want 0010", dev_sel); end
        n_checks++; if (dev_wdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL b2b_wdata: got %h want cafe0001", dev_wdata); end
        n_checks++; if (dev_addr !== 8'h44) begin n_fail++; $display("FAIL b2b_addr: got %h want 44", dev_addr); end
        dev_ack = 4'b0010;
        tick();
        dev_ack = 4'b0000;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", cpu_ready); end
        n_checks++; if (cpu_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rdata: got %h want 22222222", cpu_rdata); end
        tick();
    endtask

    initial begin
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_ack   = 4'b0000;
        // Slots 3..0 carry distinct data so a wrong slot is visible.
        dev_rdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        test_reset();
        test_read_slot2();
        test_write_slot1();
        test_reset_mid_access();
        test_out_of_window();
        test_timeout();
        test_tie_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
